window_generator: RTL and testbench
===================================

# window_generator

Streaming sliding-window generator that feeds the convolution units. Accepts a single-channel image as a raster-order pixel stream, one pixel per handshake, and emits every valid F×F window (stride 1, no padding) as one flattened bus. The bus layout is the one the conv units consume. Sits between the image source (memory reader or previous layer output) and the bank of conv units; it is the writer side of the flattened-window interface those units read.

## Interface
- DATA_WIDTH, 32, bits per pixel (float32 word, passed through untouched)
- F, 5, window edge; window holds F*F pixels
- W, 32, image width in pixels (W ≥ F)
- H, 32, image height in pixels (H ≥ F)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pixel_in  in  DATA_WIDTH  current raster pixel
- pixel_valid  in  1  pixel_in holds a pixel
- in_ready  out  1  block accepts pixel_in this cycle
- window  out  F*F*DATA_WIDTH  flattened window; element i = window[DATA_WIDTH*i +: DATA_WIDTH], i = r*F + c, r=0 top (oldest) row, c=0 leftmost column
- window_valid  out  1  window holds an unconsumed window
- window_ready  in  1  consumer takes window this cycle
- frame_done  out  1  one-cycle pulse after last window of a frame is consumed

## Operation
- Pixel accepted iff pixel_valid && in_ready.
- in_ready = !window_valid || window_ready (combinational). No pixel is dropped under backpressure.
- Column counter col (0..W-1) and row counter row (0..H-1) advance per accepted pixel. col wraps to 0 and row increments. At (H-1, W-1) both wrap to 0 and the next frame starts with no idle cycle.
- F-1 line buffers of W words each hold the previous F-1 rows. They are written every accepted pixel and are not reset.
- F×F shift array: on each accept every row shifts left by one. The new right column is {line buffers oldest→newest, pixel_in}.
- Window emitted when the accepted pixel has row ≥ F-1 and col ≥ F-1. Windows per frame = (H-F+1)*(W-F+1).
- Columns wrap across rows in the shift array. Windows with col < F-1 are never emitted, so stale columns are never visible.
- Output register: on emitting accept, window ← shifted array contents and window_valid ← 1. Otherwise, if window_ready, window_valid ← 0. A simultaneous drain and new emit keeps window_valid at 1 with the new data.
- frame_done pulses 1 cycle after the handshake (window_valid && window_ready) of the frame's final window (bottom-right).

## Timing
- Reset (synchronous) forces: row=col=0, window_valid=0, window=0, frame_done=0. This makes in_ready=1 the cycle after reset.
- Reset mid-frame discards the partial frame and any pending window. The next accepted pixel is (0,0).
- Latency: window_valid rises the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel and one window per cycle with window_ready held 1.
- While window_valid && !window_ready: window and window_valid stable, in_ready=0, counters frozen.
- pixel_valid gaps: no state change and outputs hold.

## Configuration
- WINDOW_CLEAR_EN defined: window bus driven all-zero in every cycle window_valid=0. This matches the conv units' zero-feed idle behaviour and eases waveform debug.
- WINDOW_CLEAR_EN undefined: window holds its last emitted value when window_valid=0. There is no extra mux.

## Test plan
- W=8,H=6,F=3, pixel value = r*8+c+1, window_ready=1, continuous valid.
  - Required: exactly 24 windows.
  - First window rises the cycle after pixel 19 is accepted, with elements [0..8] = 1,2,3,9,10,11,17,18,19.
  - Last window [8]=48.
  - frame_done single pulse after the 24th handshake.
- Same frame, window_ready=0 for 10 cycles at the 5th window.
  - Required: in_ready=0 and window stable throughout.
  - Afterwards: identical 24-window sequence, no loss or duplication.
- Random pixel_valid gaps (~50%).
  - Required: window sequence identical to the continuous case.
- Two back-to-back frames with no gap.
  - Required: 48 windows; frame 2's first window = 1,2,3,9,10,11,17,18,19; two frame_done pulses.
- Reset asserted after 30 accepted pixels with window_valid=1.
  - Required next cycle: window_valid=0, window=0, in_ready=1.
  - Fresh frame afterwards yields a correct first window.
- WINDOW_CLEAR_EN defined vs undefined.
  - Required: window=0 vs last value between windows; all valid windows identical in both builds.

Source files
------------

// File: rtl/window_generator.sv
// window_generator: streaming F x F sliding-window generator (stride 1, no padding).
// Takes a raster-order pixel stream and emits every fully-populated window as one
// flattened bus. Element i = r*F + c sits at window[DATA_WIDTH*i +: DATA_WIDTH].
// Row r = 0 is the oldest row and column c = 0 is the leftmost column.
// Optional build macro: WINDOW_CLEAR_EN. When it is defined, the window bus reads
// all-zero whenever window_valid is low. Otherwise the bus holds the last emitted window.
module window_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int F          = 5,
    parameter int W          = 32,
    parameter int H          = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        pixel_in,
    input  logic                         pixel_valid,
    output logic                         in_ready,
    output logic [F*F*DATA_WIDTH-1:0]    window,
    output logic                         window_valid,
    input  logic                         window_ready,
    output logic                         frame_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    // Raster position of the next pixel to be accepted
    logic [CW-1:0]                col_r;
    logic [RW-1:0]                row_r;

    // Line buffers: index 0 holds the oldest row, index F-2 holds the previous row
    logic [DATA_WIDTH-1:0]        line_r [F-1][W];

    // Working window array and its next (shifted) contents
    logic [DATA_WIDTH-1:0]        win_r   [F][F];
    logic [DATA_WIDTH-1:0]        shift_s [F][F];
    logic [F*F*DATA_WIDTH-1:0]    flat_s;

    // Output holding register
    logic [F*F*DATA_WIDTH-1:0]    window_r;
    logic                         window_valid_r;
    logic                         last_r;        // held window is the frame's bottom-right one
    logic                         frame_done_r;

    logic                         accept_s;
    logic                         emit_s;
    logic                         col_end_s;
    logic                         row_end_s;
    logic                         last_pix_s;

    assign window       = window_r;
    assign window_valid = window_valid_r;
    assign frame_done   = frame_done_r;

    // Handshake decode and window-emission conditions for the current pixel
    always_comb begin
        in_ready   = !window_valid_r || window_ready;
        accept_s   = pixel_valid && in_ready;
        col_end_s  = (col_r == CW'(W - 1));
        row_end_s  = (row_r == RW'(H - 1));
        last_pix_s = col_end_s && row_end_s;
        emit_s     = accept_s && (row_r >= RW'(F - 1)) && (col_r >= CW'(F - 1));
    end

    // Next window contents: shift every row left and load the new right column
    always_comb begin
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F - 1; c++) begin
                shift_s[r][c] = win_r[r][c + 1];
            end
        end
        for (int r = 0; r < F - 1; r++) begin
            shift_s[r][F - 1] = line_r[r][col_r];
        end
        shift_s[F - 1][F - 1] = pixel_in;
    end

    // Flatten the shifted array into the bus layout the conv units read
    always_comb begin
        flat_s = '0;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F; c++) begin
                flat_s[DATA_WIDTH * (r * F + c) +: DATA_WIDTH] = shift_s[r][c];
            end
        end
    end

    // Line buffers: shift the column down one row per accepted pixel (storage is not reset)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int k = 0; k < F - 2; k++) begin
                line_r[k][col_r] <= line_r[k + 1][col_r];
            end
            line_r[F - 2][col_r] <= pixel_in;
        end
    end

    // Window shift array; stale columns are never emitted, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept_s) begin
            win_r <= shift_s;
        end
    end

    // Raster counters; wrap straight into the next frame without an idle cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= CW'(0);
            row_r <= RW'(0);
        end else if (accept_s) begin
            if (col_end_s) begin
                col_r <= CW'(0);
                if (row_end_s) begin
                    row_r <= RW'(0);
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Output register: load on emit, drain on consume, pulse frame_done after the final window
    always_ff @(posedge clk) begin
        if (reset) begin
            window_r       <= '0;
            window_valid_r <= 1'b0;
            last_r         <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            frame_done_r <= window_valid_r && window_ready && last_r;
            if (emit_s) begin
                window_r       <= flat_s;
                window_valid_r <= 1'b1;
                last_r         <= last_pix_s;
            end else if (window_ready) begin
                window_valid_r <= 1'b0;
                last_r         <= 1'b0;
`ifdef WINDOW_CLEAR_EN
                window_r       <= '0;
`else
                window_r       <= window_r;
`endif
            end
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator using an 8x6 image and a 3x3 window.
module tb_window_generator;

    localparam int DW   = 32;
    localparam int TF   = 3;
    localparam int TW   = 8;
    localparam int TH   = 6;
    localparam int WB   = TF * TF * DW;
    localparam int NWIN = (TH - TF + 1) * (TW - TF + 1);
    localparam int NPIX = TW * TH;
`ifdef WINDOW_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          in_ready;
    logic [WB-1:0] window;
    logic          window_valid;
    logic          window_ready;
    logic          frame_done;

    window_generator #(.DATA_WIDTH(DW), .F(TF), .W(TW), .H(TH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .in_ready     (in_ready),
        .window       (window),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests_run;
    int            tests_failed;
    int            exp_idx;
    int            win_count;
    int            fd_count;
    logic          hs_last_prev;
    logic [WB-1:0] last_win;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window k of a frame: bottom-right pixel at (2 + k/6, 2 + k%6); pixel value = r*8 + c + 1
    function automatic logic [WB-1:0] exp_window(input int k);
        logic [WB-1:0] w;
        int kk, br, bc;
        kk = k % NWIN;
        br = (TF - 1) + kk / (TW - TF + 1);
        bc = (TF - 1) + kk % (TW - TF + 1);
        w  = '0;
        for (int r = 0; r < TF; r++) begin
            for (int c = 0; c < TF; c++) begin
                w[DW * (r * TF + c) +: DW] = DW'((br - TF + 1 + r) * TW + (bc - TF + 1 + c) + 1);
            end
        end
        return w;
    endfunction

    task automatic run_stream(input int npix, input bit gaps, input bit stall, input int trail);
        int            pidx;
        int            cyc;
        int            stall_left;
        int            tr;
        bit            stalled;
        bit            first_pending;
        logic [WB-1:0] snap;
        pidx = 0; cyc = 0; stall_left = 0; stalled = 1'b0; first_pending = 1'b0;
        tr = trail; snap = '0;
        exp_idx = 0; win_count = 0; fd_count = 0; hs_last_prev = 1'b0;
        while (1) begin
            if (pidx >= npix) begin
                if (tr == 0) break;
                tr--;
            end
            if (cyc >= 3000) begin
                check("timeout", WB'(pidx), WB'(npix));
                break;
            end
            cyc++;
            pixel_valid = (pidx < npix) && (!gaps || ($urandom_range(0, 1) == 1));
            pixel_in    = DW'((pidx % NPIX) + 1);
            if (stall && !stalled && window_valid && (win_count == 4)) begin
                stalled    = 1'b1;
                stall_left = 10;
                snap       = window;
            end
            window_ready = (stall_left == 0);
            @(negedge clk);
            check("in_ready", WB'(in_ready), WB'(!window_valid || window_ready));
            check("frame_done", WB'(frame_done), WB'(hs_last_prev));
            if (frame_done) fd_count++;
            if (first_pending) begin
                check("first_latency", WB'(window_valid), WB'(1));
                first_pending = 1'b0;
            end
            if (stall_left > 0) begin
                check("stall_in_ready", WB'(in_ready), WB'(0));
                check("stall_window", window, snap);
                check("stall_valid", WB'(window_valid), WB'(1));
                stall_left--;
            end
            hs_last_prev = 1'b0;
            if (window_valid && window_ready) begin
                check("window", window, exp_window(exp_idx));
                exp_idx++;
                win_count++;
                last_win     = window;
                hs_last_prev = ((exp_idx % NWIN) == 0);
            end else if (!window_valid) begin
                check("idle_window", window, CLEAR ? WB'(0) : last_win);
            end
            if (pixel_valid && in_ready) begin
                if ((pidx % NPIX) == (TF - 1) * TW + (TF - 1)) begin
                    if (pidx < NPIX) check("pre_first", WB'(window_valid), WB'(0));
                    first_pending = 1'b1;
                end
                pidx++;
            end
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
    endtask

    task automatic end_checks(input int nwin, input int nfd);
        check("win_count", WB'(win_count), WB'(nwin));
        check("fd_count", WB'(fd_count), WB'(nfd));
        check("last_elem8", WB'(last_win[8 * DW +: DW]), WB'(48));
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        exp_idx = 0; win_count = 0; fd_count = 0; hs_last_prev = 1'b0; last_win = '0;
        reset = 1'b1; pixel_valid = 1'b0; pixel_in = '0; window_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_valid", WB'(window_valid), WB'(0));
        check("reset_window", window, WB'(0));
        check("reset_in_ready", WB'(in_ready), WB'(1));
        check("reset_frame_done", WB'(frame_done), WB'(0));

        // Continuous frame
        run_stream(NPIX, 1'b0, 1'b0, 5);
        end_checks(NWIN, 1);

        // Backpressure on the 5th window
        run_stream(NPIX, 1'b0, 1'b1, 5);
        end_checks(NWIN, 1);

        // Random input gaps
        run_stream(NPIX, 1'b1, 1'b0, 5);
        end_checks(NWIN, 1);

        // Two back-to-back frames
        run_stream(2 * NPIX, 1'b0, 1'b0, 5);
        end_checks(2 * NWIN, 2);

        // Reset mid-frame while a window is pending
        run_stream(30, 1'b0, 1'b0, 0);
        check("pre_reset_valid", WB'(window_valid), WB'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_win = '0;
        check("mid_reset_valid", WB'(window_valid), WB'(0));
        check("mid_reset_window", window, WB'(0));
        check("mid_reset_in_ready", WB'(in_ready), WB'(1));
        run_stream(NPIX, 1'b0, 1'b0, 5);
        end_checks(NWIN, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
